switch_ctrl: RTL and testbench

- Scan controller for the 19 board DIP switches.
- Synchronises and debounces `switch_i`, then holds a stable switch image.
- Records per-bit change events as sticky flags and raises an interrupt request.
- Exposes stable image, change flags and a control register to the CPU through the memorio chip-select/read/write bus, in place of raw switch sampling.

---
 rtl/switch_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_switch_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_ctrl.sv
// ---------------------------------------------------------------------------
// switch_ctrl
//   Scan controller for the 19 board DIP switches. The raw switches are
//   synchronised, sampled on a slow divider tick and debounced. Once a new
//   value has been seen on STABLE_CNT consecutive ticks it becomes the stable
//   image. Every bit that changes sets a sticky change flag, and the flags can
//   raise a level interrupt. The CPU reaches the block through the memorio
//   chip-select/read/write bus.
//
// Parameters
//   SAMPLE_DIV : swcclk cycles between debounce sample ticks (>= 2)
//   STABLE_CNT : consecutive identical samples needed to commit (1..15)
//
// Ports
//   swcclk   in   1   system clock
//   swcrst   in   1   asynchronous reset, active-low
//   swcs     in   1   chip select from memorio
//   swread   in   1   read strobe  (data registered on negedge swcclk)
//   swwrite  in   1   write strobe (takes effect on posedge swcclk)
//   swaddr   in   4   register address low bits
//   swwdata  in  16   CPU write data
//   swrdata  out 16   CPU read data (holds its value when not selected)
//   swirq    out  1   interrupt request, level, active-high
//   switch_i in  19   raw board switches
//
// Register map (swcs=1)
//   0x0 R    stable[15:0]
//   0x2 R    {13'b0, stable[18:16]}
//   0x4 R/W1C chg[15:0]
//   0x6 R/W1C {13'b0, chg[18:16]}
//   0x8 R/W  {14'b0, freeze, irq_en}
// ---------------------------------------------------------------------------
module switch_ctrl #(
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_CNT = 4
) (
    input  logic        swcclk,
    input  logic        swcrst,
    input  logic        swcs,
    input  logic        swread,
    input  logic        swwrite,
    input  logic [3:0]  swaddr,
    input  logic [15:0] swwdata,
    output logic [15:0] swrdata,
    output logic        swirq,
    input  logic [18:0] switch_i
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [3:0] STABLE_N = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [18:0]      sync1_r;
    logic [18:0]      sync2_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    logic [18:0]      cand_r;
    logic [3:0]       run_r;
    logic [18:0]      stable_r;
    logic [18:0]      chg_r;
    logic [1:0]       ctrl_r;

    logic             rd_s;
    logic             wr_s;
    logic             freeze_s;
    logic             commit_s;
    logic [18:0]      set_s;
    logic [18:0]      w1c_s;
    logic [15:0]      rmux_s;

    assign rd_s     = swcs & swread;
    assign wr_s     = swcs & swwrite;
    assign freeze_s = ctrl_r[1];

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            sync1_r <= 19'd0;
            sync2_r <= 19'd0;
        end else begin
            sync1_r <= switch_i;
            sync2_r <= sync1_r;
        end
    end

    // Sample divider; tick is high for the one cycle in which the count is back at 0.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            tick_r <= (div_r == DIV_LAST);
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Commit only happens when the COMMIT cycle is not overridden by freeze.
    always_comb begin
        commit_s = 1'b0;
        set_s    = 19'd0;
        if ((state_r == ST_COMMIT) && !freeze_s) begin
            commit_s = 1'b1;
            set_s    = stable_r ^ cand_r;
        end else begin
            commit_s = 1'b0;
            set_s    = 19'd0;
        end
    end

    // Write-one-to-clear mask for the change flags.
    always_comb begin
        w1c_s = 19'd0;
        if (wr_s && (swaddr == 4'h4)) begin
            w1c_s[15:0] = swwdata;
        end else if (wr_s && (swaddr == 4'h6)) begin
            w1c_s[18:16] = swwdata[2:0];
        end else begin
            w1c_s = 19'd0;
        end
    end

    // Debounce FSM: candidate tracking and run counter; freeze parks it in IDLE.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            state_r <= ST_IDLE;
            cand_r  <= 19'd0;
            run_r   <= 4'd0;
        end else if (freeze_s) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_r && (sync2_r != stable_r)) begin
                        cand_r  <= sync2_r;
                        run_r   <= 4'd1;
                        state_r <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (tick_r) begin
                        if (sync2_r != cand_r) begin
                            cand_r <= sync2_r;
                            run_r  <= 4'd1;
                        end else if (cand_r == stable_r) begin
                            // The input bounced back to the committed value.
                            state_r <= ST_IDLE;
                        end else if ((run_r + 4'd1) >= STABLE_N) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            run_r <= run_r + 4'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stable image and sticky change flags; a same-cycle set beats a W1C clear.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            stable_r <= 19'd0;
            chg_r    <= 19'd0;
        end else begin
            if (commit_s) begin
                stable_r <= cand_r;
            end
            chg_r <= (chg_r & ~w1c_s) | set_s;
        end
    end

    // Control register {freeze, irq_en}.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            ctrl_r <= 2'd0;
        end else if (wr_s && (swaddr == 4'h8)) begin
            ctrl_r <= swwdata[1:0];
        end
    end

    // Registered level interrupt.
    always_ff @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            swirq <= 1'b0;
        end else begin
            swirq <= ctrl_r[0] & (|chg_r);
        end
    end

    // Read data mux.
    always_comb begin
        rmux_s = 16'd0;
        case (swaddr)
            4'h0:    rmux_s = stable_r[15:0];
            4'h2:    rmux_s = {13'd0, stable_r[18:16]};
            4'h4:    rmux_s = chg_r[15:0];
            4'h6:    rmux_s = {13'd0, chg_r[18:16]};
            4'h8:    rmux_s = {14'd0, ctrl_r};
            default: rmux_s = 16'd0;
        endcase
    end

    // Read data is captured mid-cycle so it is settled for the CPU's next posedge,
    // which also means a simultaneous write is seen only by later reads.
    always_ff @(negedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            swrdata <= 16'd0;
        end else if (rd_s) begin
            swrdata <= rmux_s;
        end
    end

endmodule

// File: tb/tb_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_switch_ctrl
//   Self-checking bench for switch_ctrl with SAMPLE_DIV=4, STABLE_CNT=3.
//   The reference model describes debouncing as "the last STABLE_CNT tick
//   samples are all equal and differ from the stable image", with a sample
//   history that freeze and reset discard.
// ---------------------------------------------------------------------------
module tb_switch_ctrl;

    localparam int D = 4;
    localparam int N = 3;

    logic        swcclk = 1'b0;
    logic        swcrst = 1'b1;
    logic        swcs = 1'b0;
    logic        swread = 1'b0;
    logic        swwrite = 1'b0;
    logic [3:0]  swaddr = 4'h0;
    logic [15:0] swwdata = 16'h0000;
    logic [15:0] swrdata;
    logic        swirq;
    logic [18:0] switch_i = 19'd0;

    int n_checks = 0;
    int n_fail = 0;

    switch_ctrl #(.SAMPLE_DIV(D), .STABLE_CNT(N)) dut (
        .swcclk   (swcclk),
        .swcrst   (swcrst),
        .swcs     (swcs),
        .swread   (swread),
        .swwrite  (swwrite),
        .swaddr   (swaddr),
        .swwdata  (swwdata),
        .swrdata  (swrdata),
        .swirq    (swirq),
        .switch_i (switch_i)
    );

    always #5 swcclk = ~swcclk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [18:0] m_s1, m_s2, m_stable, m_chg, m_cand;
    logic [1:0]  m_ctrl;
    logic        m_irq, m_pending;
    logic [15:0] m_rdata;
    int          m_n;
    logic [18:0] hist[$];
    logic [18:0] t_set, t_clr, t_stable, t_cand;
    logic [1:0]  t_ctrl;
    logic        t_pending, t_same;

    always @(posedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            m_s1 = 19'd0; m_s2 = 19'd0; m_stable = 19'd0; m_chg = 19'd0;
            m_cand = 19'd0; m_ctrl = 2'd0; m_irq = 1'b0; m_pending = 1'b0;
            m_n = 0;
            hist.delete();
        end else begin
            t_set = 19'd0; t_clr = 19'd0; t_stable = m_stable; t_cand = m_cand;
            t_ctrl = m_ctrl; t_pending = 1'b0;
            if (m_ctrl[1]) begin
                hist.delete();
            end else begin
                if (m_pending) begin
                    t_set = m_stable ^ m_cand;
                    t_stable = m_cand;
                end
                if (m_n >= D && (m_n % D) == 0) begin
                    hist.push_back(m_s2);
                    if (hist.size() > N) void'(hist.pop_front());
                    t_same = (hist.size() == N);
                    for (int i = 1; i < hist.size(); i++)
                        if (hist[i] != hist[0]) t_same = 1'b0;
                    if (t_same && hist[0] != m_stable) begin
                        t_pending = 1'b1;
                        t_cand = hist[0];
                        hist.delete();
                    end
                end
            end
            if (swcs && swwrite) begin
                if (swaddr == 4'h4) t_clr[15:0] = swwdata;
                if (swaddr == 4'h6) t_clr[18:16] = swwdata[2:0];
                if (swaddr == 4'h8) t_ctrl = swwdata[1:0];
            end
            m_irq = m_ctrl[0] && (m_chg != 19'd0);
            m_chg = (m_chg & ~t_clr) | t_set;
            m_stable = t_stable;
            m_cand = t_cand;
            m_pending = t_pending;
            m_ctrl = t_ctrl;
            m_s2 = m_s1;
            m_s1 = switch_i;
            m_n++;
        end
    end

    always @(negedge swcclk or negedge swcrst) begin
        if (!swcrst) begin
            m_rdata = 16'h0000;
        end else if (swcs && swread) begin
            case (swaddr)
                4'h0:    m_rdata = m_stable[15:0];
                4'h2:    m_rdata = {13'd0, m_stable[18:16]};
                4'h4:    m_rdata = m_chg[15:0];
                4'h6:    m_rdata = {13'd0, m_chg[18:16]};
                4'h8:    m_rdata = {14'd0, m_ctrl};
                default: m_rdata = 16'h0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge swcclk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        swcs = 1'b1; swread = 1'b1; swaddr = a;
        cyc(1);
        d = swrdata;
        swcs = 1'b0; swread = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        swcs = 1'b1; swwrite = 1'b1; swaddr = a; swwdata = d;
        cyc(1);
        swcs = 1'b0; swwrite = 1'b0;
    endtask

    task automatic do_reset(input logic [18:0] sw);
        swcs = 1'b0; swread = 1'b0; swwrite = 1'b0;
        switch_i = sw;
        #2 swcrst = 1'b0;
        #4 swcrst = 1'b1;
        @(posedge swcclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [15:0] d;
        #2 swcrst = 1'b0;
        #1;
        n_checks++;
        if (swrdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", swrdata); end
        n_checks++;
        if (swirq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", swirq); end
        #4 swcrst = 1'b1;
        @(posedge swcclk);
        #1;
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_stable got=%h exp=0000", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_chg got=%h exp=0000", d); end
        bus_read(4'h8, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0000", d); end
    endtask

    task automatic test_clean();
        logic [15:0] d;
        do_reset(19'd0);
        switch_i = 19'h00005;
        swcs = 1'b1; swread = 1'b1; swaddr = 4'h0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            n_checks++;
            if (swrdata !== m_rdata) begin n_fail++; $display("FAIL clean_model i=%0d got=%h exp=%h", i, swrdata, m_rdata); end
            if (i == 7) begin
                n_checks++;
                if (swrdata !== 16'h0000) begin n_fail++; $display("FAIL clean_early got=%h exp=0000", swrdata); end
            end
        end
        n_checks++;
        if (swrdata !== 16'h0005) begin n_fail++; $display("FAIL clean_stable got=%h exp=0005", swrdata); end
        swcs = 1'b0; swread = 1'b0;
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0005) begin n_fail++; $display("FAIL clean_chg got=%h exp=0005", d); end
    endtask

    task automatic test_bounce();
        int          seg_len[5];
        logic [18:0] seg_val[5];
        logic [15:0] d;
        seg_len = '{D, D, D, D, 3 * D + 4};
        seg_val = '{19'd1, 19'd0, 19'd1, 19'd1, 19'd1};
        do_reset(19'd0);
        swcs = 1'b1; swread = 1'b1; swaddr = 4'h0;
        for (int s = 0; s < 5; s++) begin
            switch_i = seg_val[s];
            for (int i = 0; i < seg_len[s]; i++) begin
                cyc(1);
                n_checks++;
                if (swrdata !== m_rdata) begin n_fail++; $display("FAIL bounce_model s=%0d got=%h exp=%h", s, swrdata, m_rdata); end
            end
            if (s == 3) begin
                n_checks++;
                if (swrdata !== 16'h0000) begin n_fail++; $display("FAIL bounce_early got=%h exp=0000", swrdata); end
            end
        end
        n_checks++;
        if (swrdata !== 16'h0001) begin n_fail++; $display("FAIL bounce_commit got=%h exp=0001", swrdata); end
        // Short pulse seen on only two ticks must be ignored.
        do_reset(19'd0);
        switch_i = 19'd1;
        cyc(2 * D);
        switch_i = 19'd0;
        cyc(5 * D);
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL pulse_stable got=%h exp=0000", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL pulse_chg got=%h exp=0000", d); end
    endtask

    task automatic test_upper();
        logic [15:0] d;
        do_reset(19'd0);
        switch_i = 19'h60000;
        cyc(6 * D + 4);
        bus_read(4'h2, d);
        n_checks++;
        if (d !== 16'h0006) begin n_fail++; $display("FAIL upper_stable got=%h exp=0006", d); end
        bus_read(4'h6, d);
        n_checks++;
        if (d !== 16'h0006) begin n_fail++; $display("FAIL upper_chg got=%h exp=0006", d); end
        bus_write(4'h6, 16'h0002);
        bus_read(4'h6, d);
        n_checks++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL upper_w1c got=%h exp=0004", d); end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        bit          found;
        n_checks++;
        if (swirq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got=%b exp=0", swirq); end
        bus_write(4'h8, 16'h0001);
        n_checks++;
        if (swirq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got=%b exp=0", swirq); end
        cyc(1);
        n_checks++;
        if (swirq !== 1'b1) begin n_fail++; $display("FAIL irq_enable got=%b exp=1", swirq); end
        bus_write(4'h4, 16'hFFFF);
        bus_write(4'h6, 16'hFFFF);
        n_checks++;
        if (swirq !== 1'b1) begin n_fail++; $display("FAIL irq_clr_lag got=%b exp=1", swirq); end
        cyc(1);
        n_checks++;
        if (swirq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared got=%b exp=0", swirq); end
        // Land a W1C of bit0 exactly on the commit that sets bit0.
        switch_i = 19'h60001;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (m_pending) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL irq_commit_wait got=timeout exp=commit"); end
        bus_write(4'h4, 16'h0001);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0001) begin n_fail++; $display("FAIL set_wins got=%h exp=0001", d); end
        n_checks++;
        if (swirq !== 1'b1) begin n_fail++; $display("FAIL irq_after_set got=%b exp=1", swirq); end
    endtask

    task automatic test_freeze();
        logic [15:0] d;
        bus_write(4'h8, 16'h0002);
        switch_i = 19'h00F00;
        cyc(10 * D + 4);
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 16'h0001) begin n_fail++; $display("FAIL freeze_lo got=%h exp=0001", d); end
        bus_read(4'h2, d);
        n_checks++;
        if (d !== 16'h0006) begin n_fail++; $display("FAIL freeze_hi got=%h exp=0006", d); end
        bus_write(4'h8, 16'h0000);
        swcs = 1'b1; swread = 1'b1; swaddr = 4'h0;
        cyc(2 * D);
        n_checks++;
        if (swrdata !== 16'h0001) begin n_fail++; $display("FAIL unfreeze_early got=%h exp=0001", swrdata); end
        cyc(D + 4);
        n_checks++;
        if (swrdata !== 16'h0F00) begin n_fail++; $display("FAIL unfreeze_commit got=%h exp=0F00", swrdata); end
        swcs = 1'b0; swread = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        bus_write(4'h8, 16'h0001);
        cyc(2);
        n_checks++;
        if (swirq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pre got=%b exp=1", swirq); end
        switch_i = 19'h00033;
        cyc(D + 3);
        #2 swcrst = 1'b0;
        #1;
        n_checks++;
        if (swrdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata got=%h exp=0000", swrdata); end
        n_checks++;
        if (swirq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got=%b exp=0", swirq); end
        switch_i = 19'd0;
        #3 swcrst = 1'b1;
        @(posedge swcclk);
        #1;
        cyc(10 * D);
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_stale got=%h exp=0000", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_chg got=%h exp=0000", d); end
        switch_i = 19'h00033;
        cyc(6 * D);
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 16'h0033) begin n_fail++; $display("FAIL mid_redeb got=%h exp=0033", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 16'h0033) begin n_fail++; $display("FAIL mid_redeb_chg got=%h exp=0033", d); end
    endtask

    task automatic test_random();
        logic [18:0] masks[4];
        int          hold;
        int          op;
        masks = '{19'h00001, 19'h0000F, 19'h70000, 19'h7FFFF};
        do_reset(19'd0);
        for (int it = 0; it < 250; it++) begin
            switch_i = 19'($urandom) & masks[$urandom_range(0, 3)];
            hold = $urandom_range(1, 4 * D);
            for (int c = 0; c < hold; c++) begin
                op = $urandom_range(0, 11);
                swcs = 1'b0; swread = 1'b0; swwrite = 1'b0;
                if (op <= 5) begin
                    swcs = 1'b1; swread = 1'b1;
                    swaddr = (op == 5) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4) * 2);
                end else if (op == 6 || op == 7) begin
                    swcs = 1'b1; swwrite = 1'b1; swread = 1'($urandom_range(0, 1));
                    swaddr = (op == 6) ? 4'h4 : 4'h6;
                    swwdata = 16'($urandom);
                end else if (op == 8) begin
                    swcs = 1'b1; swwrite = 1'b1; swaddr = 4'h8;
                    swwdata = ($urandom_range(0, 7) == 0) ? 16'h0002 : 16'($urandom_range(0, 1));
                end else begin
                    swaddr = 4'($urandom_range(0, 15));
                end
                cyc(1);
                n_checks++;
                if (swrdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata it=%0d got=%h exp=%h", it, swrdata, m_rdata); end
                n_checks++;
                if (swirq !== m_irq) begin n_fail++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, swirq, m_irq); end
            end
        end
        swcs = 1'b0; swread = 1'b0; swwrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_upper();
        test_irq();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
